// File: rtl/demorgan_exerciser_pkg.sv
// Purpose: shared FSM encoding, vector limits and obs/exp bit indices for the exerciser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demorgan_exerciser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } exState_t;

  // Bit positions of the eight gate outputs within obs/exp.
  localparam int OBS_NA      = 0;
  localparam int OBS_NB      = 1;
  localparam int OBS_NAANDNB = 2;
  localparam int OBS_NAORNB  = 3;
  localparam int OBS_AANDB   = 4;
  localparam int OBS_NAANDB  = 5;
  localparam int OBS_AORB    = 6;
  localparam int OBS_NAORB   = 7;

  localparam int          OBS_W    = 8;
  localparam logic [1:0]  LAST_VEC = 2'd3;

endpackage

// File: rtl/demorgan_exerciser_if.sv
// Purpose: bundles the stimulus pair and the eight observed outputs of the gate block.
// Latency: none; plain wires between exerciser and gate block.
// Backpressure: none; the gate block is combinational and sampled by time.
interface demorgan_exerciser_if;
  logic A;
  logic B;
  logic nA;
  logic nB;
  logic nAandnB;
  logic nAornB;
  logic AandB;
  logic nAandB;
  logic AorB;
  logic nAorB;

  // Exerciser side: drives A/B, observes the gate outputs.
  modport master (
    output A, B,
    input  nA, nB, nAandnB, nAornB, AandB, nAandB, AorB, nAorB
  );

  // Gate block side.
  modport slave (
    input  A, B,
    output nA, nB, nAandnB, nAornB, AandB, nAandB, AorB, nAorB
  );
endinterface

// File: rtl/demorgan_exerciser_expect.sv
// Purpose: expected gate outputs for one {A,B} vector, straight from the truth table.
// Latency: combinational.
// Backpressure: none.
module demorgan_expect
  import demorgan_exerciser_pkg::*;
(
  input  logic [1:0]       vec,
  output logic [OBS_W-1:0] expected
);

  // Truth table rows, bit order [7:0] = ~(A|B), A|B, ~(A&B), A&B, ~A|~B, ~A&~B, ~B, ~A.
  always_comb begin
    expected = '0;
    unique case (vec)
      2'b00: expected = 8'b1010_1111;
      2'b01: expected = 8'b0110_1001;
      2'b10: expected = 8'b0110_1010;
      2'b11: expected = 8'b0101_0000;
    endcase
  end

endmodule

// File: rtl/demorgan_exerciser.sv
// Purpose: sweeps {A,B} through 00..11, samples the gate block after a settle window, scores it.
// Latency: SETTLE_CYCLES+1 cycles per vector; done rises 4*(SETTLE_CYCLES+1) cycles after start.
// Backpressure: none; start is ignored while busy, results hold until the next start or reset.
module demorgan_exerciser
  import demorgan_exerciser_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  demorgan_exerciser_if.master  gate,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2:0]            err_count,
  output logic [1:0]            first_fail_vec,
  output logic [OBS_W-1:0]      first_fail_mask
);

  localparam int              CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  exState_t         state;
  exState_t         nextState;
  logic [1:0]       vec;
  logic [CNT_W-1:0] settleCnt;
  logic [OBS_W-1:0] obs;
  logic [OBS_W-1:0] expected;
  logic [OBS_W-1:0] mask;
  logic             mismatch;
  logic [2:0]       errNext;

  // The register holding the vector index is the stimulus itself, so A/B never glitch.
  assign gate.A = vec[1];
  assign gate.B = vec[0];

  demorgan_expect uExpect (
    .vec      (vec),
    .expected (expected)
  );

  // Gather the gate outputs into obs bit order and score them against the truth table.
  always_comb begin
    obs                 = '0;
    obs[OBS_NA]         = gate.nA;
    obs[OBS_NB]         = gate.nB;
    obs[OBS_NAANDNB]    = gate.nAandnB;
    obs[OBS_NAORNB]     = gate.nAornB;
    obs[OBS_AANDB]      = gate.AandB;
    obs[OBS_NAANDB]     = gate.nAandB;
    obs[OBS_AORB]       = gate.AorB;
    obs[OBS_NAORB]      = gate.nAorB;
    mask                = obs ^ expected;
    mismatch            = |mask;
    errNext             = err_count + {2'b00, mismatch};
  end

  // Next-state: start launches from IDLE/DONE, settle window ends in a one-cycle CHECK.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE, DONE: if (start) nextState = SETTLE;
      SETTLE:     if (settleCnt == SETTLE_LAST) nextState = CHECK;
      CHECK:      nextState = (vec == LAST_VEC) ? DONE : SETTLE;
    endcase
  end

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Counters and result registers; results clear on the same edge that accepts start.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec             <= '0;
      settleCnt       <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_vec  <= '0;
      first_fail_mask <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            vec             <= '0;
            settleCnt       <= '0;
            busy            <= 1'b1;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
          end
        end
        SETTLE: begin
          settleCnt <= settleCnt + 1'b1;
        end
        CHECK: begin
          // At most four vectors can fail, so the 3-bit count never wraps.
          if (mismatch) begin
            err_count <= errNext;
            if (err_count == 3'd0) begin
              first_fail_vec  <= vec;
              first_fail_mask <= mask;
            end
          end
          if (vec == LAST_VEC) begin
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (errNext == 3'd0);
          end else begin
            vec       <= vec + 2'd1;
            settleCnt <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demorgan_exerciser.sv
// Purpose: directed bench for demorgan_exerciser against a behavioural gate block with faults.
// Latency: checks done exactly 8 cycles after start at SETTLE_CYCLES=1.
// Backpressure: n/a.
module tb_demorgan_exerciser;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] faultMode;   // 0: healthy, 1: nAorB stuck at 0, 2: every output inverted
  logic       inv;

  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] errCount;
  logic [1:0] firstFailVec;
  logic [7:0] firstFailMask;

  int vecCount  = 0;
  int missCount = 0;

  always #5 clk = ~clk;

  demorgan_exerciser_if gate ();

  // Behavioural gate block with injectable faults.
  assign inv          = (faultMode == 2'd2);
  assign gate.nA      = (~gate.A) ^ inv;
  assign gate.nB      = (~gate.B) ^ inv;
  assign gate.nAandnB = ((~gate.A) & (~gate.B)) ^ inv;
  assign gate.nAornB  = ((~gate.A) | (~gate.B)) ^ inv;
  assign gate.AandB   = (gate.A & gate.B) ^ inv;
  assign gate.nAandB  = (~(gate.A & gate.B)) ^ inv;
  assign gate.AorB    = (gate.A | gate.B) ^ inv;
  assign gate.nAorB   = (faultMode == 2'd1) ? 1'b0 : ((~(gate.A | gate.B)) ^ inv);

  demorgan_exerciser #(.SETTLE_CYCLES(1)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .gate            (gate),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_count       (errCount),
    .first_fail_vec  (firstFailVec),
    .first_fail_mask (firstFailMask)
  );

  task automatic expectEq(input string tag, input logic [7:0] got, input logic [7:0] want);
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, follow the A/B sequence cycle by cycle, then score the results.
  task automatic runSweep(input string name, input logic extraStarts, input logic expPass,
                          input logic [2:0] expErr, input logic [1:0] expVec,
                          input logic [7:0] expMask);
    start = 1'b1;
    tick();
    start = 1'b0;
    expectEq({name, " busy@0"}, {7'd0, busy}, 8'd1);
    expectEq({name, " done@0"}, {7'd0, done}, 8'd0);
    expectEq({name, " err@0"}, {5'd0, errCount}, 8'd0);
    expectEq({name, " mask@0"}, firstFailMask, 8'h00);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      expectEq($sformatf("%s AB@%0d", name, k), {6'd0, gate.A, gate.B}, 8'(k / 2));
      if (extraStarts) start = (k == 2 || k == 5);
    end
    start = 1'b0;
    expectEq({name, " done@7"}, {7'd0, done}, 8'd0);
    tick();
    expectEq({name, " done@8"}, {7'd0, done}, 8'd1);
    expectEq({name, " busy@8"}, {7'd0, busy}, 8'd0);
    expectEq({name, " pass"}, {7'd0, pass}, {7'd0, expPass});
    expectEq({name, " err"}, {5'd0, errCount}, {5'd0, expErr});
    expectEq({name, " fvec"}, {6'd0, firstFailVec}, {6'd0, expVec});
    expectEq({name, " fmask"}, firstFailMask, expMask);
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    faultMode = 2'd0;
    tick();
    tick();
    expectEq("rst busy", {7'd0, busy}, 8'd0);
    expectEq("rst done", {7'd0, done}, 8'd0);
    expectEq("rst pass", {7'd0, pass}, 8'd0);
    expectEq("rst err", {5'd0, errCount}, 8'd0);
    expectEq("rst fvec", {6'd0, firstFailVec}, 8'd0);
    expectEq("rst fmask", firstFailMask, 8'h00);
    expectEq("rst AB", {6'd0, gate.A, gate.B}, 8'd0);
    reset = 1'b0;
    tick();

    runSweep("clean", 1'b0, 1'b1, 3'd0, 2'b00, 8'h00);

    faultMode = 2'd1;
    runSweep("stuck", 1'b0, 1'b0, 3'd1, 2'b00, 8'h80);

    faultMode = 2'd2;
    runSweep("invert", 1'b0, 1'b0, 3'd4, 2'b00, 8'hFF);

    // Results must hold with no start for ten cycles.
    repeat (10) tick();
    expectEq("hold done", {7'd0, done}, 8'd1);
    expectEq("hold pass", {7'd0, pass}, 8'd0);
    expectEq("hold err", {5'd0, errCount}, 8'd4);
    expectEq("hold fmask", firstFailMask, 8'hFF);

    faultMode = 2'd0;
    runSweep("restart", 1'b0, 1'b1, 3'd0, 2'b00, 8'h00);

    runSweep("ignore", 1'b1, 1'b1, 3'd0, 2'b00, 8'h00);

    // Abort a faulty sweep after two vectors have been scored.
    faultMode = 2'd2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    expectEq("pre-abort err", {5'd0, errCount}, 8'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expectEq("abort busy", {7'd0, busy}, 8'd0);
    expectEq("abort done", {7'd0, done}, 8'd0);
    expectEq("abort AB", {6'd0, gate.A, gate.B}, 8'd0);
    expectEq("abort err", {5'd0, errCount}, 8'd0);
    expectEq("abort fmask", firstFailMask, 8'h00);
    repeat (10) tick();
    expectEq("idle done", {7'd0, done}, 8'd0);
    expectEq("idle busy", {7'd0, busy}, 8'd0);

    faultMode = 2'd0;
    runSweep("post-reset", 1'b0, 1'b1, 3'd0, 2'b00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
